issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, cycles flush_o is held after a taken redirect; legal range 1..15.
REQ-002 Parameter: NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 dec_valid_i  in  1  decoded instruction present.
REQ-006 rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  register addresses from decode.
REQ-007 uses_rs1_i, uses_rs2_i, reg_write_en_i  in  1 each  operand-use and writeback flags from decode.
REQ-008 branch_i, jump_i  in  1 each  control-transfer flags from decode; jalr is reported as jump_i.
REQ-009 issue_ready_i  in  1  execute stage accepts an instruction this cycle.
REQ-010 wb_valid_i, wb_rd_i  in  1, 5  writeback retiring a write to wb_rd_i.
REQ-011 resolve_valid_i, resolve_taken_i  in  1, 1  execute resolved the outstanding branch or jump.
REQ-012 issue_valid_o  out  1  instruction may issue.
REQ-013 dec_ready_o  out  1  decode may advance; equals issue fire.
REQ-014 stall_o  out  1  dec_valid_i high and no issue this cycle.
REQ-015 flush_o  out  1  drop fetched and decoded instructions.
REQ-016 scoreboard_o  out  NUM_REGS  pending-write bit per register.

Function
REQ-017 Hazard = dec_valid_i AND any of: (uses_rs1_i, rs1!=0, sb[rs1]), (uses_rs2_i, rs2!=0, sb[rs2]), (reg_write_en_i, rd!=0, sb[rd]) (RAW, RAW, WAW).
REQ-018 issue_valid_o = dec_valid_i AND state==RUN AND NOT hazard; purely combinational, no added latency.
REQ-019 Fire = issue_valid_o AND issue_ready_i; dec_ready_o = fire; stall_o = dec_valid_i AND NOT fire.
REQ-020 Fire with reg_write_en_i and rd!=0 sets sb[rd] at the next edge.
REQ-021 wb_valid_i with wb_rd_i!=0 clears sb[wb_rd_i] at the next edge; wb to x0 is ignored.
REQ-022 Set and clear of the same bit in one cycle: set wins.
REQ-023 sb[0] is constant 0.
REQ-024 States: RUN, WAIT_CTRL, FLUSH.
REQ-025 RUN -> WAIT_CTRL on fire with branch_i or jump_i.
REQ-026 In WAIT_CTRL, issue_valid_o=0. On resolve_valid_i: taken -> FLUSH and load the counter with FLUSH_CYCLES; not taken -> RUN.
REQ-027 In FLUSH, flush_o=1 and issue_valid_o=0. The counter decrements each cycle; when it reaches 1 the next state is RUN. flush_o is high for exactly FLUSH_CYCLES cycles.
REQ-028 resolve_valid_i outside WAIT_CTRL is ignored.
REQ-029 Scoreboard updates from writeback continue in every state; flush never modifies the scoreboard, because nothing issues after a control transfer.

Reset
REQ-030 rst_n low asynchronously forces state RUN, counter 0 and scoreboard all-zero, from any state including mid-flush or WAIT_CTRL.
REQ-031 While in reset: flush_o=0, scoreboard_o=0, issue_valid_o and dec_ready_o follow REQ-018/019 against an empty scoreboard.

Configuration
REQ-032 Macro ISSUE_CTRL_WB_BYPASS_EN.
- Defined: a source register matching wb_rd_i while wb_valid_i is high is treated as not pending for the RAW and WAW checks in that same cycle.
- Undefined: the hazard is evaluated only on the registered scoreboard, so issue waits one cycle after writeback.

Structure
REQ-033 Shared package core_pkg holds: enum issue_state_e {ST_RUN, ST_WAIT_CTRL, ST_FLUSH}; constant REG_ADDR_W=5; constant NUM_ARCH_REGS=32.
REQ-034 Sub-module reg_scoreboard holds the set/clear bit vector (REQ-020..023) and exposes per-port pending lookups; issue_ctrl holds the FSM and the counter.

Verification
REQ-035 Issue add x5 (reg_write, rd=5, ready=1), next cycle dec add x6,x5,x1 -> issue_valid_o=0, stall_o=1 until wb_valid_i with wb_rd_i=5; issues 1 cycle later (0 cycles with the bypass).
REQ-036 addi x0 writes, then a reader of x0 -> scoreboard_o stays 0 and no stall occurs.
REQ-037 beq fires -> WAIT_CTRL with issue_valid_o=0; resolve_valid_i=1, resolve_taken_i=0 -> RUN next cycle, flush_o never asserted.
REQ-038 jal fires, resolve taken, FLUSH_CYCLES=2 -> flush_o high for exactly 2 cycles, then issue resumes.
REQ-039 Same cycle: wb_rd_i=7 and fire with rd=7 (bypass build) -> sb[7]=1 afterwards.
REQ-040 rst_n dropped during FLUSH with sb=0x0000_00A0 -> flush_o=0 and scoreboard_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the issue stage: issue FSM states and register-file geometry.
package core_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_CTRL,
        ST_FLUSH
    } issue_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bit per architectural register, with set-over-clear priority and x0 hardwired clear.
// With ISSUE_CTRL_WB_BYPASS_EN defined, a same-cycle writeback hides its register from the lookups.
module reg_scoreboard
    import core_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  rs1_pend_o,
    output logic                  rs2_pend_o,
    output logic                  rd_pend_o,
    output logic [NUM_REGS-1:0]   sb_o
);

    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_clr_vec;
    logic [NUM_REGS-1:0] w_sel_rs1;
    logic [NUM_REGS-1:0] w_sel_rs2;
    logic [NUM_REGS-1:0] w_sel_rd;
    logic [NUM_REGS-1:0] w_live;

    // Bit 0 is never set, so with a zero reset it stays zero forever.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign w_set_vec[gi] = (gi != 0) && set_en_i && (set_addr_i == REG_ADDR_W'(gi));
            assign w_clr_vec[gi] = clr_en_i && (clr_addr_i == REG_ADDR_W'(gi));
            assign w_sel_rs1[gi] = (rs1_addr_i == REG_ADDR_W'(gi));
            assign w_sel_rs2[gi] = (rs2_addr_i == REG_ADDR_W'(gi));
            assign w_sel_rd[gi]  = (rd_addr_i  == REG_ADDR_W'(gi));
        end
    endgenerate

`ifdef ISSUE_CTRL_WB_BYPASS_EN
    assign w_live = r_sb & ~w_clr_vec;
`else
    assign w_live = r_sb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~w_clr_vec) | w_set_vec;
        end
    end

    assign rs1_pend_o = |(w_live & w_sel_rs1);
    assign rs2_pend_o = |(w_live & w_sel_rs2);
    assign rd_pend_o  = |(w_live & w_sel_rd);
    assign sb_o       = r_sb;

endmodule

// File: rtl/issue_ctrl.sv
// Issue gate: blocks RAW/WAW hazards against reg_scoreboard and holds issue across branches/jumps,
// flushing for FLUSH_CYCLES after a taken redirect. Optional macro: ISSUE_CTRL_WB_BYPASS_EN.
module issue_ctrl
    import core_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int NUM_REGS     = NUM_ARCH_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  uses_rs1_i,
    input  logic                  uses_rs2_i,
    input  logic                  reg_write_en_i,
    input  logic                  branch_i,
    input  logic                  jump_i,
    input  logic                  issue_ready_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  resolve_valid_i,
    input  logic                  resolve_taken_i,
    output logic                  issue_valid_o,
    output logic                  dec_ready_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [NUM_REGS-1:0]   scoreboard_o
);

    issue_state_e r_state;
    logic [3:0]   r_flush_cnt;
    logic         r_flush;

    logic w_rs1_pend;
    logic w_rs2_pend;
    logic w_rd_pend;
    logic w_hazard;
    logic w_issue_valid;
    logic w_fire;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (w_fire && reg_write_en_i),
        .set_addr_i (rd_addr_i),
        .clr_en_i   (wb_valid_i),
        .clr_addr_i (wb_rd_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rd_addr_i  (rd_addr_i),
        .rs1_pend_o (w_rs1_pend),
        .rs2_pend_o (w_rs2_pend),
        .rd_pend_o  (w_rd_pend),
        .sb_o       (scoreboard_o)
    );

    // x0 never reads as pending, so address-zero operands drop out of the hazard naturally.
    assign w_hazard = dec_valid_i && ((uses_rs1_i && w_rs1_pend) ||
                                      (uses_rs2_i && w_rs2_pend) ||
                                      (reg_write_en_i && w_rd_pend));

    assign w_issue_valid = dec_valid_i && (r_state == ST_RUN) && !w_hazard;
    assign w_fire        = w_issue_valid && issue_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
            r_flush     <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_fire && (branch_i || jump_i)) begin
                        r_state <= ST_WAIT_CTRL;
                    end
                end
                ST_WAIT_CTRL: begin
                    if (resolve_valid_i) begin
                        if (resolve_taken_i) begin
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= 4'(FLUSH_CYCLES);
                            r_flush     <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == 4'd1) begin
                        r_state     <= ST_RUN;
                        r_flush_cnt <= '0;
                        r_flush     <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_flush_cnt <= '0;
                    r_flush     <= 1'b0;
                end
            endcase
        end
    end

    assign issue_valid_o = w_issue_valid;
    assign dec_ready_o   = w_fire;
    assign stall_o       = dec_valid_i && !w_fire;
    assign flush_o       = r_flush;

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized and directed bench for issue_ctrl: a reference model predicts each cycle's outputs
// into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_issue_ctrl;

    localparam int FC = 2;
`ifdef ISSUE_CTRL_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic       dv, u1, u2, we, br, jp, rdy, wbv, rv, rt;
        logic [4:0] rs1, rs2, rd, wbr;
    } stim_t;

    typedef struct {
        logic        iv, dr, st, fl;
        logic [31:0] sb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid_i = 1'b0;
    logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0, wb_rd_i = '0;
    logic        uses_rs1_i = 1'b0, uses_rs2_i = 1'b0, reg_write_en_i = 1'b0;
    logic        branch_i = 1'b0, jump_i = 1'b0, issue_ready_i = 1'b0;
    logic        wb_valid_i = 1'b0, resolve_valid_i = 1'b0, resolve_taken_i = 1'b0;
    logic        issue_valid_o, dec_ready_o, stall_o, flush_o;
    logic [31:0] scoreboard_o;

    int checks = 0;
    int failures = 0;
    int txn = 0;
    exp_t exp_q[$];

    // Reference model: which registers await a write, and where the control-flow hold stands.
    bit [31:0] pend = '0;
    int        mode = 0;        // 0 issuing, 1 awaiting resolve, 2 flushing
    int        flush_left = 0;

    issue_ctrl #(.FLUSH_CYCLES(FC), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .uses_rs1_i(uses_rs1_i), .uses_rs2_i(uses_rs2_i), .reg_write_en_i(reg_write_en_i),
        .branch_i(branch_i), .jump_i(jump_i), .issue_ready_i(issue_ready_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
        .issue_valid_o(issue_valid_o), .dec_ready_o(dec_ready_o), .stall_o(stall_o),
        .flush_o(flush_o), .scoreboard_o(scoreboard_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{dv:0, u1:0, u2:0, we:0, br:0, jp:0, rdy:0, wbv:0, rv:0, rt:0,
              rs1:0, rs2:0, rd:0, wbr:0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.dv  = ($urandom % 4) != 0;
        s.u1  = $urandom % 2;  s.u2 = $urandom % 2;  s.we = $urandom % 2;
        s.rs1 = 5'($urandom % 8); s.rs2 = 5'($urandom % 8); s.rd = 5'($urandom % 8);
        s.br  = ($urandom % 16) == 0;
        s.jp  = ($urandom % 24) == 0;
        s.rdy = ($urandom % 4) != 0;
        s.wbv = ($urandom % 3) == 0;
        s.wbr = 5'($urandom % 8);
        s.rv  = ($urandom % 3) == 0;
        s.rt  = $urandom % 2;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        dec_valid_i = s.dv; uses_rs1_i = s.u1; uses_rs2_i = s.u2; reg_write_en_i = s.we;
        rs1_addr_i = s.rs1; rs2_addr_i = s.rs2; rd_addr_i = s.rd;
        branch_i = s.br; jump_i = s.jp; issue_ready_i = s.rdy;
        wb_valid_i = s.wbv; wb_rd_i = s.wbr;
        resolve_valid_i = s.rv; resolve_taken_i = s.rt;
    endtask

    function automatic bit is_pending(input logic [4:0] r, input stim_t s);
        if (r == 0 || !pend[r]) return 1'b0;
        if (BYP && s.wbv && s.wbr == r) return 1'b0;
        return 1'b1;
    endfunction

    // One clock of stimulus: predict outputs, enqueue, then advance the model at the edge.
    task automatic cycle(input stim_t s);
        exp_t e;
        bit   haz, fire;
        drive(s);
        haz  = s.dv && ((s.u1 && is_pending(s.rs1, s)) || (s.u2 && is_pending(s.rs2, s)) ||
                        (s.we && is_pending(s.rd, s)));
        e.iv = s.dv && (mode == 0) && !haz;
        fire = e.iv && s.rdy;
        e.dr = fire;
        e.st = s.dv && !fire;
        e.fl = (mode == 2);
        e.sb = pend;
        exp_q.push_back(e);
        @(posedge clk);
        if (s.wbv && s.wbr != 0) pend[s.wbr] = 1'b0;
        if (fire && s.we && s.rd != 0) pend[s.rd] = 1'b1;
        if (mode == 0) begin
            if (fire && (s.br || s.jp)) mode = 1;
        end else if (mode == 1) begin
            if (s.rv) begin
                if (s.rt) begin mode = 2; flush_left = FC; end
                else mode = 0;
            end
        end else begin
            flush_left--;
            if (flush_left == 0) mode = 0;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d iv=%0b rdy=%0b stall=%0b flush=%0b sb=%08h", txn,
                         issue_valid_o, dec_ready_o, stall_o, flush_o, scoreboard_o);
                check("issue_valid", 32'(issue_valid_o), 32'(e.iv));
                check("dec_ready",   32'(dec_ready_o),   32'(e.dr));
                check("stall",       32'(stall_o),       32'(e.st));
                check("flush",       32'(flush_o),       32'(e.fl));
                check("scoreboard",  scoreboard_o,       e.sb);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        // Reset held: outputs follow an empty scoreboard, nothing gets recorded.
        s = idle(); s.dv = 1; s.we = 1; s.rd = 5; s.u1 = 1; s.rs1 = 5; s.rdy = 1;
        drive(s);
        #12;
        check("rst_issue_valid", 32'(issue_valid_o), 32'd1);
        check("rst_dec_ready",   32'(dec_ready_o),   32'd1);
        check("rst_stall",       32'(stall_o),       32'd0);
        check("rst_flush",       32'(flush_o),       32'd0);
        @(posedge clk); #3;
        check("rst_scoreboard",  scoreboard_o,       32'd0);
        drive(idle());
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // RAW on x5 through writeback
        s = idle(); s.dv = 1; s.we = 1; s.rd = 5; s.rdy = 1; cycle(s);
        s = idle(); s.dv = 1; s.u1 = 1; s.u2 = 1; s.rs1 = 5; s.rs2 = 1; s.we = 1; s.rd = 6; s.rdy = 1;
        cycle(s); cycle(s);
        s.wbv = 1; s.wbr = 5; cycle(s);
        s.wbv = 0; cycle(s);
        s = idle(); s.wbv = 1; s.wbr = 6; cycle(s);
        // x0 writer then x0 reader
        s = idle(); s.dv = 1; s.we = 1; s.rd = 0; s.rdy = 1; cycle(s);
        s = idle(); s.dv = 1; s.u1 = 1; s.rs1 = 0; s.rdy = 1; cycle(s);
        // beq not taken
        s = idle(); s.dv = 1; s.u1 = 1; s.u2 = 1; s.rs1 = 1; s.rs2 = 2; s.br = 1; s.rdy = 1; cycle(s);
        s = idle(); s.dv = 1; s.rdy = 1; cycle(s);
        s.rv = 1; s.rt = 0; cycle(s);
        s.rv = 0; cycle(s);
        // jal taken, flush window
        s = idle(); s.dv = 1; s.jp = 1; s.we = 1; s.rd = 1; s.rdy = 1; cycle(s);
        s = idle(); s.rv = 1; s.rt = 1; cycle(s);
        s = idle(); s.dv = 1; s.rdy = 1; cycle(s); cycle(s); cycle(s);
        s = idle(); s.wbv = 1; s.wbr = 1; cycle(s);
        // same-cycle writeback and set of x7: set wins
        s = idle(); s.dv = 1; s.we = 1; s.rd = 7; s.rdy = 1; s.wbv = 1; s.wbr = 7; cycle(s);
        s = idle(); cycle(s);
        s = idle(); s.wbv = 1; s.wbr = 7; cycle(s);

        for (int i = 0; i < 400; i++) cycle(rand_stim());

        // Drain scoreboard and control hold
        for (int r = 1; r < 32; r++) begin
            s = idle(); s.wbv = 1; s.wbr = 5'(r); s.rv = 1; s.rt = 0; cycle(s);
        end
        for (int i = 0; i < FC + 2; i++) cycle(idle());

        // Build sb=0xA0 and sit in FLUSH, then reset asynchronously mid-cycle
        s = idle(); s.dv = 1; s.we = 1; s.rd = 5; s.rdy = 1; cycle(s);
        s.rd = 7; cycle(s);
        s = idle(); s.dv = 1; s.jp = 1; s.rdy = 1; cycle(s);
        s = idle(); s.rv = 1; s.rt = 1; cycle(s);
        #2;
        check("pre_rst_flush", 32'(flush_o), 32'd1);
        check("pre_rst_sb",    scoreboard_o, 32'h0000_00A0);
        s = idle(); s.dv = 1; s.u1 = 1; s.rs1 = 5; s.rdy = 1; drive(s);
        rst_n = 1'b0;
        #1;
        check("async_rst_flush", 32'(flush_o), 32'd0);
        check("async_rst_sb",    scoreboard_o, 32'd0);
        check("async_rst_issue", 32'(issue_valid_o), 32'd1);
        drive(idle());
        pend = '0; mode = 0; flush_left = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) cycle(rand_stim());

        @(negedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
